// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its IF/ID register.
package fetch_pkg;

  typedef enum logic [1:0] {
    F_REQ,
    F_WAIT,
    F_HOLD
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus, one request outstanding at a time.
interface fetch_stage_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, idle cycles load a bubble.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             deliver,
  input  fetch_pkg::if_id_t din,
  output fetch_pkg::if_id_t dout
);

  // Bubbles keep pc/pc_plus4 so Decode still sees the last real PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout.instr    <= NOP_INSTR;
      dout.pc       <= 32'h0;
      dout.pc_plus4 <= 32'h0;
      dout.valid    <= 1'b0;
    end else if (flush_d || (!stall_d && !deliver)) begin
      dout.instr <= NOP_INSTR;
      dout.valid <= 1'b0;
    end else if (deliver) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding fetch FSM with skid register, IF/ID register.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_f,
  input  logic                 stall_d,
  input  logic                 flush_d,
  input  logic                 pc_src_e,
  input  logic [31:0]          pc_target_e,
  fetch_stage_if.master        imem,
  output logic [31:0]          instr_d,
  output logic [31:0]          pc_d,
  output logic [31:0]          pc_plus4_d,
  output logic                 valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_bubbles
`endif
);

  import fetch_pkg::*;

  fetch_state_t state_reg;
  logic [31:0]  pc_f_reg;
  logic [31:0]  skid_reg;
  logic         discard_reg;

  logic [31:0]  pc_plus4_f;
  logic [31:0]  target_aligned;
  logic         ready_d;
  logic         rsp_live;
  logic         deliver;
  if_id_t       if_id_next;
  if_id_t       if_id_q;

  assign pc_plus4_f     = pc_inc(pc_f_reg);
  assign target_aligned = pc_target_e & ~32'd3;

  assign imem.req  = (state_reg == F_REQ) && !stall_f && !reset;
  assign imem.addr = pc_f_reg;

  // A flush blocks acceptance like a stall, so the word goes to the skid
  // register instead of being lost; only a redirect throws it away.
  assign ready_d  = !stall_d && !flush_d;
  assign rsp_live = (state_reg == F_WAIT) && imem.rvalid && !discard_reg;
  assign deliver  = !pc_src_e && ready_d && (rsp_live || (state_reg == F_HOLD));

  assign if_id_next = '{
    instr:    (state_reg == F_HOLD) ? skid_reg : imem.rdata,
    pc:       pc_f_reg,
    pc_plus4: pc_plus4_f,
    valid:    1'b1
  };

  // Fetch FSM and PC; a redirect overrides every other event this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= F_REQ;
      pc_f_reg    <= RESET_PC;
      skid_reg    <= 32'h0;
      discard_reg <= 1'b0;
    end else if (pc_src_e) begin
      pc_f_reg <= target_aligned;
      case (state_reg)
        F_REQ: begin
          if (imem.req && imem.gnt) begin
            state_reg   <= F_WAIT;
            discard_reg <= 1'b1;
          end
        end
        F_WAIT: begin
          if (imem.rvalid) begin
            state_reg   <= F_REQ;
            discard_reg <= 1'b0;
          end else begin
            discard_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= F_REQ;
          discard_reg <= 1'b0;
        end
      endcase
    end else begin
      case (state_reg)
        F_REQ: begin
          if (imem.req && imem.gnt) state_reg <= F_WAIT;
        end
        F_WAIT: begin
          if (imem.rvalid) begin
            if (discard_reg) begin
              discard_reg <= 1'b0;
              state_reg   <= F_REQ;
            end else if (ready_d) begin
              pc_f_reg  <= pc_plus4_f;
              state_reg <= F_REQ;
            end else begin
              skid_reg  <= imem.rdata;
              state_reg <= F_HOLD;
            end
          end
        end
        default: begin
          if (ready_d) begin
            pc_f_reg  <= pc_plus4_f;
            state_reg <= F_REQ;
          end
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .stall_d (stall_d),
    .flush_d (flush_d),
    .deliver (deliver),
    .din     (if_id_next),
    .dout    (if_id_q)
  );

  assign instr_d    = if_id_q.instr;
  assign pc_d       = if_id_q.pc;
  assign pc_plus4_d = if_id_q.pc_plus4;
  assign valid_d    = if_id_q.valid;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_bubbles_reg;
  logic        bubble_evt;

  assign bubble_evt = flush_d || (!stall_d && !deliver);

  // Delivery and bubble counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_reg <= 32'h0;
      perf_bubbles_reg <= 32'h0;
    end else begin
      if (deliver)    perf_fetched_reg <= perf_fetched_reg + 32'd1;
      if (bubble_evt) perf_bubbles_reg <= perf_bubbles_reg + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_bubbles = perf_bubbles_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected requests and
// IF/ID deliveries; a negedge monitor pops and compares.
module tb_fetch_stage;

  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem        (imem),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  // Memory: latches the granted address; the word is only meaningful while rvalid.
  logic [31:0] mem_addr_q = 32'h0;
  always @(posedge clk) if (imem.req && imem.gnt) mem_addr_q <= imem.addr;
  assign imem.rdata = imem.rvalid ? (32'hC0DE_0000 | {16'h0, mem_addr_q[15:0]}) : 32'hDEAD_BEEF;

  int passed = 0;
  int total  = 0;
  int exp_fetched = 0;
  int load_edges  = 0;
  logic [31:0] exp_req_q[$];
  logic [95:0] exp_del_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic exp_req(input logic [31:0] a);
    exp_req_q.push_back(a);
  endtask

  task automatic exp_del(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] p4);
    exp_del_q.push_back({w, pc, p4});
    exp_fetched++;
  endtask

  // One cycle of stimulus: gnt, rvalid, stall_f, stall_d, flush_d, pc_src_e, target.
  task automatic cyc(input logic g, input logic rv, input logic sf, input logic sd,
                     input logic fl, input logic ps, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    imem.gnt    = g;
    imem.rvalid = rv;
    stall_f     = sf;
    stall_d     = sd;
    flush_d     = fl;
    pc_src_e    = ps;
    pc_target_e = tgt;
  endtask

  task automatic fetch2();
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 32'h0);
  endtask

  // Monitor: inputs sampled here are the ones the next posedge will act on.
  logic pend_load = 1'b0;
  logic pend_flush = 1'b0;
  initial begin
    logic [95:0] e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (pend_load || pend_flush) begin
        if (valid_d === 1'b1 && !pend_flush) begin
          if (exp_del_q.size() == 0) begin
            total++;
            $display("FAIL delivery: got unexpected pc_d %h required none", pc_d);
          end else begin
            e = exp_del_q.pop_front();
            check("instr_d", instr_d, e[95:64]);
            check("pc_d", pc_d, e[63:32]);
            check("pc_plus4_d", pc_plus4_d, e[31:0]);
            $display("deliver instr=%h pc=%h pc4=%h", instr_d, pc_d, pc_plus4_d);
          end
        end else begin
          check("bubble_instr", instr_d, NOP_INSTR);
          check("bubble_valid", {31'b0, valid_d}, 32'h0);
          $display("bubble pc=%h flush=%0d", pc_d, pend_flush);
        end
      end
      if (imem.req === 1'b1 && imem.gnt === 1'b1) begin
        if (exp_req_q.size() == 0) begin
          total++;
          $display("FAIL imem_req: got unexpected addr %h required none", imem.addr);
        end else begin
          a = exp_req_q.pop_front();
          check("imem_addr", imem.addr, a);
          $display("request addr=%h", imem.addr);
        end
      end
      pend_load  = !reset && !stall_d && !flush_d;
      pend_flush = !reset && flush_d;
      if (pend_load || pend_flush) load_edges++;
    end
  end

  initial begin
    reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_e = 1'b0; pc_target_e = 32'h0; imem.gnt = 1'b0; imem.rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    check("rst_instr_d", instr_d, NOP_INSTR);
    check("rst_pc_d", pc_d, 32'h0);
    check("rst_pc_plus4_d", pc_plus4_d, 32'h0);
    check("rst_valid_d", {31'b0, valid_d}, 32'h0);
    check("rst_imem_req", {31'b0, imem.req}, 32'h0);
    check("rst_imem_addr", imem.addr, 32'h0);

    // Back-to-back fetches: 0, 4, 8.
    exp_req(32'h0); exp_del(32'hC0DE_0000, 32'h0, 32'h4);
    exp_req(32'h4); exp_del(32'hC0DE_0004, 32'h4, 32'h8);
    exp_req(32'h8); exp_del(32'hC0DE_0008, 32'h8, 32'hC);
    repeat (3) fetch2();

    // stall_d across rvalid: word parks in skid, no new request.
    exp_req(32'hC); exp_del(32'hC0DE_000C, 32'hC, 32'h10);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 1, 0, 0, 32'h0);
      #3;
      check("hold_req", {31'b0, imem.req}, 32'h0);
      check("hold_pc_d", pc_d, 32'h8);
      check("hold_valid_d", {31'b0, valid_d}, 32'h0);
    end
    cyc(0, 0, 0, 0, 0, 0, 32'h0);

    // Redirect while waiting; late response dropped.
    exp_req(32'h10);
    exp_req(32'h100); exp_del(32'hC0DE_0100, 32'h100, 32'h104);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 32'h0);
    fetch2();

    // Redirect + flush with same-cycle rvalid; unaligned target.
    exp_req(32'h104);
    exp_req(32'h200); exp_del(32'hC0DE_0200, 32'h200, 32'h204);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 1, 1, 32'h203);
    fetch2();

    // Flush alone on delivery: word survives via skid.
    exp_req(32'h204); exp_del(32'hC0DE_0204, 32'h204, 32'h208);
    cyc(1, 0, 0, 0, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 1, 0, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h0);

    // Redirect in the grant cycle: that request's response is discarded.
    exp_req(32'h208);
    exp_req(32'h40); exp_del(32'hC0DE_0040, 32'h40, 32'h44);
    cyc(1, 0, 0, 0, 0, 1, 32'h40);
    cyc(0, 1, 0, 0, 0, 0, 32'h0);
    fetch2();

    // PC wrap at the top of the address space.
    exp_req(32'hFFFF_FFFC); exp_del(32'hC0DE_FFFC, 32'hFFFF_FFFC, 32'h0);
    exp_req(32'h0); exp_del(32'hC0DE_0000, 32'h0, 32'h4);
    cyc(0, 0, 1, 0, 0, 1, 32'hFFFF_FFFC);
    fetch2();
    fetch2();

    // Flush overrides stall_d.
    cyc(0, 0, 1, 1, 1, 0, 32'h0);
    cyc(0, 0, 1, 1, 1, 0, 32'h0);

    // Quiesce: IF/ID frozen, no requests.
    repeat (3) cyc(0, 0, 1, 1, 0, 0, 32'h0);
    #3;
    check("req_queue_left", exp_req_q.size(), 32'h0);
    check("del_queue_left", exp_del_q.size(), 32'h0);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, exp_fetched);
    check("perf_bubbles", perf_bubbles, load_edges - exp_fetched);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register for the 5-stage RISC-V core. Consumes the hazard unit's stall_f, stall_d, flush_d and the Execute redirect (pc_src_e, pc_target_e).
- Fetches over a variable-latency instruction memory interface with one request outstanding at a time.
- Presents the Decode stage with either an instruction or a NOP bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall_f  in  1  blocks issuing a new fetch request
- stall_d  in  1  holds the IF/ID register
- flush_d  in  1  loads a bubble into IF/ID
- pc_src_e  in  1  redirect taken in Execute
- pc_target_e  in  32  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; equals pc_f
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; at most one per granted request
- imem_rdata  in  32  instruction word
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc_plus4_d  out  32  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction

Behaviour:
- Reset state: pc_f=RESET_PC, FSM=F_REQ, discard=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, imem_req=0.
- FSM states:
  - F_REQ: imem_req = !stall_f && !reset.
  - F_WAIT: one request outstanding.
  - F_HOLD: response captured in the skid register; IF/ID is stalled.
- F_REQ: imem_req && imem_gnt -> F_WAIT. pc_f holds until delivery.
- F_WAIT, on imem_rvalid:
  - If discard=1: drop the word, clear discard, go to F_REQ.
  - Else if !stall_d: IF/ID <= {imem_rdata, pc_f, pc_f+4}, valid_d=1, pc_f <= pc_f+4, go to F_REQ.
  - Else: skid <= imem_rdata, go to F_HOLD.
- F_HOLD with !stall_d: IF/ID <= {skid, pc_f, pc_f+4}, valid_d=1, pc_f <= pc_f+4, go to F_REQ.
- Bubble: if nothing is delivered in a cycle and !stall_d, IF/ID loads instr_d=NOP_INSTR, valid_d=0, and pc_d/pc_plus4_d hold their values.
- stall_d=1 and !flush_d: IF/ID holds all fields.
- flush_d: IF/ID loads the bubble. flush_d overrides stall_d and any same-cycle delivery, but that delivered word is not lost unless pc_src_e is also high.
- pc_src_e has priority over stall_f, stall_d and delivery:
  - pc_f <= {pc_target_e[31:2],2'b00}.
  - F_WAIT with no same-cycle rvalid -> stay in F_WAIT, discard=1.
  - F_WAIT with same-cycle rvalid -> drop the word, go to F_REQ.
  - F_HOLD -> drop the skid, go to F_REQ.
  - F_REQ with same-cycle gnt -> F_WAIT, discard=1.
- Latency: gnt and rvalid in consecutive cycles give one instruction per 2 cycles. Fetch is not pipelined.
- Arithmetic: pc_f+4 wraps modulo 2^32. 32'hFFFF_FFFC -> 32'h0000_0000.
- Reset mid-transaction: the in-flight response is ignored until reset deasserts. The memory guarantees no rvalid after reset without a new gnt.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32) and perf_bubbles (32), both reset to 0 and wrapping.
  - perf_fetched increments on each delivery into IF/ID.
  - perf_bubbles increments on each cycle IF/ID loads a bubble.
- Undefined: neither port nor counter exists.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum logic [1:0] {F_REQ, F_WAIT, F_HOLD} fetch_state_t;
  - constant NOP_INSTR;
  - packed struct if_id_t {instr, pc, pc_plus4, valid}.
- One natural sub-module: if_id_reg (IF/ID register with stall/flush/bubble priority). The FSM and PC logic stay in fetch_stage.

Test Plan:
- Reset release, memory grants immediately and rvalid 1 cycle later -> imem_addr sequence 0,4,8. instr_d/pc_d update every 2 cycles. valid_d=1 on the first delivery.
- stall_d=1 for 3 cycles while rvalid arrives -> FSM=F_HOLD, IF/ID unchanged, no imem_req. On release, IF/ID loads the skid word with its pc_d.
- pc_src_e=1, pc_target_e=32'h0000_0100 while in F_WAIT, rvalid 2 cycles later -> word dropped, valid_d=0, next imem_addr=32'h100.
- pc_src_e and flush_d with same-cycle rvalid -> bubble loaded (instr_d=32'h13, valid_d=0), next request at the target.
- pc_target_e=32'h0000_0203 -> imem_addr=32'h0000_0200. pc_f=32'hFFFF_FFFC delivery -> pc_plus4_d=0, next imem_addr=0.
- FETCH_PERF_EN defined, 10 deliveries plus 4 flushes -> perf_fetched=10, perf_bubbles counts every bubble cycle, including the 4 flush cycles.
